// File: rtl/gray_frame_ctrl.sv
// Frame sequencer and credit-based flow controller around a fixed-latency rgb2gray converter.
// Define GRAY_FRAME_CTRL_RESYNC_EN to restart the frame on an unexpected s_sof during RUN.
module gray_frame_ctrl #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int CVT_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        busy,
  output logic        frame_done,
  output logic        err_sync,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_rgb,
  input  logic        s_sof,
  output logic        cvt_din_valid,
  output logic [7:0]  cvt_r,
  output logic [7:0]  cvt_g,
  output logic [7:0]  cvt_b,
  input  logic        cvt_dout_valid,
  input  logic [7:0]  cvt_gray,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_gray,
  output logic        m_sof,
  output logic        m_eol,
  output logic        m_eof
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef GRAY_FRAME_CTRL_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                       state_q, state_d;
  logic [XW-1:0]                x_q, x_d;
  logic [YW-1:0]                y_q, y_d;
  logic [CW-1:0]                credit_q, credit_d;
  logic                         din_valid_q, din_valid_d;
  logic [23:0]                  rgb_q, rgb_d;
  logic [2:0]                   sb_q, sb_d;
  logic [CVT_LAT-1:0]           pipe_v_q, pipe_v_d;
  logic [CVT_LAT-1:0][2:0]      pipe_sb_q, pipe_sb_d;
  logic [FIFO_DEPTH-1:0][10:0]  fifo_mem_q, fifo_mem_d;
  logic [AW:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                         frame_done_q, frame_done_d;
  logic                         err_sync_q, err_sync_d;

  logic        hs, pop, wr, issue, issue_sof, issue_eol, issue_eof;
  logic [10:0] head;

  // RUN only admits a beat when its FIFO slot is already reserved, so the converter never stalls.
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      IDLE:    s_ready = enable;
      RUN:     s_ready = (credit_q < CW'(FIFO_DEPTH));
      default: s_ready = 1'b0;
    endcase
  end

  assign hs  = s_valid & s_ready;
  assign pop = m_valid & m_ready;
  // Converter output is only trusted if the sideband says a pixel was issued since reset.
  assign wr  = cvt_dout_valid & pipe_v_q[CVT_LAT-1];

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    issue        = 1'b0;
    issue_sof    = 1'b0;
    issue_eol    = 1'b0;
    issue_eof    = 1'b0;
    err_sync_d   = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs && s_sof) begin
          issue     = 1'b1;
          issue_sof = 1'b1;
          x_d       = XW'(1);
          y_d       = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (hs) begin
          issue = 1'b1;
          if (RESYNC && s_sof) begin
            err_sync_d = 1'b1;
            issue_sof  = 1'b1;
            x_d        = XW'(1);
            y_d        = '0;
          end else begin
            issue_eol = (x_q == XW'(IMG_W - 1));
            issue_eof = issue_eol && (y_q == YW'(IMG_H - 1));
            if (issue_eol) begin
              x_d = '0;
              y_d = issue_eof ? '0 : y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
            if (issue_eof) state_d = DRAIN;
          end
        end
      end
      default: ;
    endcase
    credit_d = credit_q + CW'(issue) - CW'(pop);
    if (state_q == DRAIN && credit_d == '0) begin
      state_d      = IDLE;
      frame_done_d = 1'b1;
    end
    din_valid_d = issue;
    rgb_d       = issue ? s_rgb : rgb_q;
    sb_d        = {issue_sof, issue_eol, issue_eof};
  end

  for (genvar gi = 0; gi < CVT_LAT; gi++) begin : g_pipe
    if (gi == 0) begin : g_first
      assign pipe_v_d[gi]  = din_valid_q;
      assign pipe_sb_d[gi] = sb_q;
    end else begin : g_next
      assign pipe_v_d[gi]  = pipe_v_q[gi-1];
      assign pipe_sb_d[gi] = pipe_sb_q[gi-1];
    end
  end

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    if (wr) fifo_mem_d[wr_ptr_q[AW-1:0]] = {cvt_gray, pipe_sb_q[CVT_LAT-1]};
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      credit_q     <= '0;
      din_valid_q  <= 1'b0;
      rgb_q        <= '0;
      sb_q         <= '0;
      pipe_v_q     <= '0;
      pipe_sb_q    <= '0;
      fifo_mem_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      frame_done_q <= 1'b0;
      err_sync_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      credit_q     <= credit_d;
      din_valid_q  <= din_valid_d;
      rgb_q        <= rgb_d;
      sb_q         <= sb_d;
      pipe_v_q     <= pipe_v_d;
      pipe_sb_q    <= pipe_sb_d;
      fifo_mem_q   <= fifo_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_done_q <= frame_done_d;
      err_sync_q   <= err_sync_d;
    end
  end

  assign head          = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign m_valid       = (wr_ptr_q != rd_ptr_q);
  assign m_gray        = head[10:3];
  assign m_sof         = m_valid & head[2];
  assign m_eol         = m_valid & head[1];
  assign m_eof         = m_valid & head[0];
  assign cvt_din_valid = din_valid_q;
  assign cvt_r         = rgb_q[23:16];
  assign cvt_g         = rgb_q[15:8];
  assign cvt_b         = rgb_q[7:0];
  assign busy          = (state_q != IDLE);
  assign frame_done    = frame_done_q;
  assign err_sync      = err_sync_q;

endmodule

// File: tb/tb_gray_frame_ctrl.sv
// Self-checking bench for gray_frame_ctrl: converter model plus a pixel-index scoreboard.
// Define GRAY_FRAME_CTRL_RESYNC_EN to also exercise mid-frame resynchronisation.
module tb_gray_frame_ctrl;
  localparam int W = 4, H = 2, LAT = 1, FD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;
`ifdef GRAY_FRAME_CTRL_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic clk, rst_n, enable, busy, frame_done, err_sync;
  logic s_valid, s_ready, s_sof;
  logic [23:0] s_rgb;
  logic cvt_din_valid;
  logic [7:0] cvt_r, cvt_g, cvt_b;
  logic cvt_dout_valid = 1'b0;
  logic [7:0] cvt_gray = 8'h00;
  logic m_valid, m_ready, m_sof, m_eol, m_eof;
  logic [7:0] m_gray;

  gray_frame_ctrl #(.IMG_W(W), .IMG_H(H), .CVT_LAT(LAT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .busy(busy), .frame_done(frame_done),
    .err_sync(err_sync), .s_valid(s_valid), .s_ready(s_ready), .s_rgb(s_rgb), .s_sof(s_sof),
    .cvt_din_valid(cvt_din_valid), .cvt_r(cvt_r), .cvt_g(cvt_g), .cvt_b(cvt_b),
    .cvt_dout_valid(cvt_dout_valid), .cvt_gray(cvt_gray), .m_valid(m_valid), .m_ready(m_ready),
    .m_gray(m_gray), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gray_of(input logic [23:0] p);
    int v;
    v = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
    return 8'(v >> 8);
  endfunction

  // Converter: one-cycle latency, not reset, so stale output can straddle a reset.
  always @(posedge clk) begin
    cvt_dout_valid <= cvt_din_valid;
    cvt_gray       <= gray_of({cvt_r, cvt_g, cvt_b});
  end

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {logic [7:0] g; logic sof, eol, eof; int t;} exp_t;
  exp_t q[$];
  exp_t e;
  int mode = M_IDLE, idx = 0, inflight = 0, cyc = 0;
  int pop_cnt = 0, fd_cnt = 0, err_cnt = 0, acc_cnt = 0;
  logic fd_exp = 0, err_exp = 0, din_exp = 0, fd_nx, err_nx, issue, pop, exp_rdy, mv_exp;
  logic [23:0] din_rgb_exp = '0;

  // Reference model: pixel index within the frame decides sof/eol/eof; inflight = issued - popped.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("rst_s_ready", s_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_err_sync", err_sync, 0);
      check("rst_cvt_din_valid", cvt_din_valid, 0);
      check("rst_cvt_rgb", {cvt_r, cvt_g, cvt_b}, 0);
      check("rst_m_out", {m_valid, m_gray, m_sof, m_eol, m_eof}, 0);
      q.delete();
      mode = M_IDLE; idx = 0; inflight = 0;
      fd_exp = 0; err_exp = 0; din_exp = 0;
    end else begin
      exp_rdy = (mode == M_IDLE) ? enable : (mode == M_RUN) ? (inflight < FD) : 1'b0;
      check("s_ready", s_ready, exp_rdy);
      check("busy", busy, mode != M_IDLE);
      check("frame_done", frame_done, fd_exp);
      check("err_sync", err_sync, err_exp);
      check("cvt_din_valid", cvt_din_valid, din_exp);
      if (din_exp) check("cvt_rgb", {cvt_r, cvt_g, cvt_b}, din_rgb_exp);
      mv_exp = (q.size() != 0) && (q[0].t + 3 <= cyc);
      check("m_valid", m_valid, mv_exp);
      if (m_valid && mv_exp)
        check("m_head", {m_gray, m_sof, m_eol, m_eof}, {q[0].g, q[0].sof, q[0].eol, q[0].eof});
      pop = m_valid && m_ready;
      if (pop) begin
        pop_cnt++;
        $display("pop %0d: gray=%02h sof=%b eol=%b eof=%b", pop_cnt, m_gray, m_sof, m_eol, m_eof);
        if (q.size() != 0) void'(q.pop_front());
      end
      if (frame_done) fd_cnt++;
      if (err_sync) err_cnt++;
      issue = 0; err_nx = 0; fd_nx = 0;
      if (s_valid && s_ready) begin
        acc_cnt++;
        if (mode == M_IDLE) begin
          if (s_sof) begin issue = 1; idx = 0; mode = M_RUN; end
        end else if (mode == M_RUN) begin
          issue = 1;
          if (RESYNC && s_sof) begin idx = 0; err_nx = 1; end
        end
      end
      if (issue) begin
        e.g = gray_of(s_rgb);
        e.sof = (idx == 0);
        e.eol = (idx % W == W - 1);
        e.eof = (idx == W * H - 1);
        e.t = cyc;
        q.push_back(e);
        din_rgb_exp = s_rgb;
        if (e.eof) begin mode = M_DRAIN; idx = 0; end else idx++;
      end
      din_exp = issue;
      inflight = inflight + int'(issue) - int'(pop);
      check("no_overflow", inflight <= FD, 1);
      if (mode == M_DRAIN && inflight == 0) begin mode = M_IDLE; fd_nx = 1; end
      fd_exp = fd_nx;
      err_exp = err_nx;
    end
  end

  task automatic send(input logic [23:0] rgb, input logic sof);
    int n = 0;
    s_valid = 1; s_rgb = rgb; s_sof = sof;
    @(negedge clk);
    while (!s_ready && n < 200) begin n++; @(negedge clk); end
    check("send_accept", n < 200, 1);
    @(posedge clk); #1;
    s_valid = 0; s_sof = 0;
  endtask

  task automatic send_frame(input int gap_max);
    int k;
    for (int i = 0; i < W * H; i++) begin
      send($urandom, i == 0);
      k = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      if (k > 0) begin repeat (k) @(posedge clk); #1; end
    end
  endtask

  task automatic wait_fd(input int target);
    int n = 0;
    while (fd_cnt < target && n < 400) begin @(posedge clk); n++; end
    check("frame_done_count", fd_cnt, target);
    #1;
  endtask

  int b_pop, b_fd, b_acc, b_err;
  logic rand_on = 0;

  initial begin
    rst_n = 0; enable = 0; s_valid = 0; s_rgb = '0; s_sof = 0; m_ready = 0;
    repeat (3) @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // Streaming
    enable = 1; m_ready = 1;
    b_pop = pop_cnt; b_fd = fd_cnt;
    send_frame(0);
    wait_fd(b_fd + 1);
    check("stream_pops", pop_cnt - b_pop, 8);

    // Hunting
    b_pop = pop_cnt; b_fd = fd_cnt; b_acc = acc_cnt;
    for (int i = 0; i < 3; i++) send($urandom, 1'b0);
    check("hunt_accepts", acc_cnt - b_acc, 3);
    check("hunt_no_pops", pop_cnt - b_pop, 0);
    send_frame(0);
    wait_fd(b_fd + 1);
    check("hunt_pops", pop_cnt - b_pop, 8);

    // Backpressure
    m_ready = 0;
    b_pop = pop_cnt; b_fd = fd_cnt; b_acc = acc_cnt;
    fork send_frame(0); join_none
    repeat (12) @(posedge clk);
    check("bp_accepts", acc_cnt - b_acc, 4);
    check("bp_pops", pop_cnt - b_pop, 0);
    #1 m_ready = 1;
    wait_fd(b_fd + 1);
    check("bp_pops_total", pop_cnt - b_pop, 8);

    // Random data, gaps, hunting noise and random m_ready
    b_fd = fd_cnt; b_pop = pop_cnt;
    rand_on = 1;
    fork
      begin
        while (rand_on) begin @(posedge clk); #1; m_ready = ($urandom_range(0, 3) != 0); end
      end
    join_none
    for (int f = 0; f < 3; f++) begin
      repeat ($urandom_range(0, 2)) send($urandom, 1'b0);
      send_frame(2);
    end
    rand_on = 0;
    @(posedge clk); #2;
    m_ready = 1;
    wait_fd(b_fd + 3);
    check("rand_pops", pop_cnt - b_pop, 24);

    // Reset mid-frame
    for (int i = 0; i < 5; i++) send($urandom, i == 0);
    rst_n = 0; enable = 0;
    @(negedge clk); #2;
    rst_n = 1;
    b_pop = pop_cnt; b_fd = fd_cnt;
    @(posedge clk); #1;
    enable = 1;
    repeat (4) @(posedge clk); #1;
    check("rst_discard_pops", pop_cnt - b_pop, 0);
    send_frame(0);
    wait_fd(b_fd + 1);
    check("rst_next_frame_pops", pop_cnt - b_pop, 8);

`ifdef GRAY_FRAME_CTRL_RESYNC_EN
    // Resync on beat 3
    b_pop = pop_cnt; b_fd = fd_cnt; b_err = err_cnt;
    send($urandom, 1'b1);
    send($urandom, 1'b0);
    send($urandom, 1'b1);
    for (int i = 0; i < 7; i++) send($urandom, 1'b0);
    wait_fd(b_fd + 1);
    check("resync_pops", pop_cnt - b_pop, 10);
    check("resync_err_pulses", err_cnt - b_err, 1);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
